shift_sequencer: RTL and testbench

Multi-cycle shift unit with an explicit controller FSM. It performs logical-left, logical-right, arithmetic-right and rotate-right on a 32-bit operand, one step per clock, under a start/busy/done handshake. It sits beside the ALU in the multi-cycle CPU datapath and replaces single-cycle shift logic for SLL/SRL/SRA-class instructions. The main control unit stalls on `busy_o` and consumes `data_o` when `done_o` is asserted.

---
 rtl/shift_sequencer.sv | 136 +++++++++++++
 tb/tb_shift_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/shift_sequencer.sv
// ---------------------------------------------------------------------------
// shift_sequencer
//
// Multi-cycle shift unit for the multi-cycle CPU datapath. It performs SLL,
// SRL, SRA and ROTR on a 32-bit operand, one position per clock, under a
// start/busy/done handshake.
//
// Optional feature: define SHIFT_SEQ_DOUBLE_STEP_EN to shift two positions
// per cycle while at least two positions remain. Results and handshake are
// identical in both builds; only the latency differs.
//
// Ports:
//   clk_i    - clock, all state updates on the rising edge
//   rst_i    - synchronous active-high reset
//   start_i  - request, sampled only in IDLE
//   op_i     - 00 SLL, 01 SRL, 10 SRA, 11 ROTR
//   data_i   - operand, captured with start_i
//   shamt_i  - shift amount 0..31, captured with start_i
//   busy_o   - high whenever the controller is not in IDLE
//   done_o   - one-cycle pulse in the DONE state
//   data_o   - result register, holds the last completed result
// ---------------------------------------------------------------------------
module shift_sequencer #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   start_i,
    input  logic [1:0]             op_i,
    input  logic [DATA_WIDTH-1:0]  data_i,
    input  logic [SHAMT_WIDTH-1:0] shamt_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [DATA_WIDTH-1:0]  data_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t                 state_q, state_d;
    logic [DATA_WIDTH-1:0]  work_q,  work_d;
    logic [SHAMT_WIDTH-1:0] count_q, count_d;
    logic [1:0]             op_q,    op_d;
    logic [DATA_WIDTH-1:0]  data_q,  data_d;

    // One single-position step of the selected operation.
    function automatic logic [DATA_WIDTH-1:0] step_one(
        input logic [1:0]            op,
        input logic [DATA_WIDTH-1:0] w
    );
        logic [DATA_WIDTH-1:0] r;
        case (op)
            2'b00:   r = {w[DATA_WIDTH-2:0], 1'b0};
            2'b01:   r = {1'b0, w[DATA_WIDTH-1:1]};
            2'b10:   r = {w[DATA_WIDTH-1], w[DATA_WIDTH-1:1]};
            default: r = {w[0], w[DATA_WIDTH-1:1]};
        endcase
        step_one = r;
    endfunction

    // State register and datapath registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            work_q  <= '0;
            count_q <= '0;
            op_q    <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            count_q <= count_d;
            op_q    <= op_d;
            data_q  <= data_d;
        end
    end

    // Next-state logic of the controller.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = SHIFT;
            SHIFT:   if (count_q == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath updates steered by the current state. The result register is
    // only written on the transition into DONE so it stays stable between
    // completions.
    always_comb begin
        work_d  = work_q;
        count_d = count_q;
        op_d    = op_q;
        data_d  = data_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    work_d  = data_i;
                    count_d = shamt_i;
                    op_d    = op_i;
                end
            end
            SHIFT: begin
                if (count_q == '0) begin
                    data_d = work_q;
`ifdef SHIFT_SEQ_DOUBLE_STEP_EN
                end else if (count_q >= SHAMT_WIDTH'(2)) begin
                    // Two chained single steps give the correct two-position
                    // result for every op, including rotate and sign fill.
                    work_d  = step_one(op_q, step_one(op_q, work_q));
                    count_d = count_q - SHAMT_WIDTH'(2);
`endif
                end else begin
                    work_d  = step_one(op_q, work_q);
                    count_d = count_q - SHAMT_WIDTH'(1);
                end
            end
            default: begin
            end
        endcase
    end

    // Moore outputs decoded from the state register.
    always_comb begin
        busy_o = (state_q != IDLE);
        done_o = (state_q == DONE);
        data_o = data_q;
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// ---------------------------------------------------------------------------
// tb_shift_sequencer
//
// Self-checking bench for shift_sequencer. A table of operations with
// hand-computed results is applied in a loop; expected results go into a
// queue when a start is driven and are popped when done_o appears. Extra
// hand-written sequences cover ignored starts during SHIFT/DONE and a reset
// in the middle of an operation. Honours SHIFT_SEQ_DOUBLE_STEP_EN for the
// expected latency.
// ---------------------------------------------------------------------------
module tb_shift_sequencer;

    logic        clk_i;
    logic        rst_i;
    logic        start_i;
    logic [1:0]  op_i;
    logic [31:0] data_i;
    logic [4:0]  shamt_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] data_o;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] d;
        logic [4:0]  sh;
        logic [31:0] exp;
    } vec_t;

    vec_t        vecs[10];
    logic [31:0] expQ[$];
    logic [31:0] lastResult;
    int          checks;
    int          errors;

    shift_sequencer dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (start_i),
        .op_i    (op_i),
        .data_i  (data_i),
        .shamt_i (shamt_i),
        .busy_o  (busy_o),
        .done_o  (done_o),
        .data_o  (data_o)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Number of edges after the capturing edge until done_o is visible.
    function automatic int expLatency(input logic [4:0] sh);
`ifdef SHIFT_SEQ_DOUBLE_STEP_EN
        expLatency = (int'(sh) + 1) / 2 + 1;
`else
        expLatency = int'(sh) + 1;
`endif
    endfunction

    // One comparison: counts it and reports a mismatch.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
        end
    endtask

    // Runs one operation from IDLE to the cycle after DONE. With disturb set,
    // start_i stays asserted with junk operands through SHIFT and DONE.
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] d,
                                 input logic [4:0] sh, input logic [31:0] exp,
                                 input bit disturb);
        int  lat;
        int  k;
        int  doneCount;
        bit  seen;
        logic [31:0] got;
        lat = expLatency(sh);
        op_i    = op;
        data_i  = d;
        shamt_i = sh;
        start_i = 1'b1;
        expQ.push_back(exp);
        @(posedge clk_i);
        #1;
        start_i = disturb;
        op_i    = ~op;
        data_i  = ~d;
        shamt_i = ~sh;
        checkOutput("busy_after_start", {31'b0, busy_o}, 32'd1);
        checkOutput("data_o_held", data_o, lastResult);
        seen = 1'b0;
        k = 0;
        doneCount = 0;
        while (!seen && k < lat + 5) begin
            @(posedge clk_i);
            #1;
            k++;
            if (disturb) data_i = $urandom;
            if (done_o) begin
                seen = 1'b1;
                doneCount++;
                checkOutput("busy_in_done", {31'b0, busy_o}, 32'd1);
                checkOutput("done_latency", 32'(k), 32'(lat));
                got = expQ.pop_front();
                checkOutput("result", data_o, got);
                lastResult = got;
            end else if (!busy_o) begin
                checkOutput("busy_during_shift", {31'b0, busy_o}, 32'd1);
            end
        end
        if (!seen) begin
            checkOutput("done_timeout", 32'd0, 32'd1);
            void'(expQ.pop_front());
        end
        // Leaves DONE; any start seen there must be dropped.
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (done_o) doneCount++;
            if (i == 0) begin
                checkOutput("busy_back_idle", {31'b0, busy_o}, 32'd0);
                checkOutput("data_o_stable", data_o, lastResult);
            end
            @(posedge clk_i);
            #1;
        end
        if (disturb) begin
            checkOutput("single_done_pulse", 32'(doneCount), 32'd1);
            checkOutput("no_queued_start", {31'b0, busy_o}, 32'd0);
        end
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        lastResult = 32'h0;
        rst_i      = 1'b1;
        start_i    = 1'b1;
        op_i       = 2'b00;
        data_i     = 32'hFFFF_FFFF;
        shamt_i    = 5'd3;

        vecs[0] = '{2'b00, 32'h0000_0001, 5'd4,  32'h0000_0010};
        vecs[1] = '{2'b10, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF};
        vecs[2] = '{2'b01, 32'h8000_0000, 5'd31, 32'h0000_0001};
        vecs[3] = '{2'b11, 32'h1234_5678, 5'd8,  32'h7812_3456};
        vecs[4] = '{2'b01, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF};
        vecs[5] = '{2'b10, 32'h7FFF_FFF0, 5'd4,  32'h07FF_FFFF};
        vecs[6] = '{2'b00, 32'hF000_000F, 5'd3,  32'h8000_0078};
        vecs[7] = '{2'b11, 32'h0000_0001, 5'd1,  32'h8000_0000};
        vecs[8] = '{2'b11, 32'h8000_0001, 5'd5,  32'h0C00_0000};
        vecs[9] = '{2'b10, 32'h8000_0000, 5'd1,  32'hC000_0000};

        // Reset held over several edges with start_i high must stay idle.
        repeat (3) @(posedge clk_i);
        #1;
        rst_i   = 1'b0;
        start_i = 1'b0;
        checkOutput("reset_busy", {31'b0, busy_o}, 32'd0);
        checkOutput("reset_done", {31'b0, done_o}, 32'd0);
        checkOutput("reset_data", data_o, 32'h0);

        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].op, vecs[i].d, vecs[i].sh, vecs[i].exp, 1'b0);
        end

        // Starts during SHIFT and DONE are dropped.
        applyStimulus(2'b11, 32'h1234_5678, 5'd8, 32'h7812_3456, 1'b1);
        applyStimulus(2'b01, 32'hDEAD_BEEF, 5'd0, 32'hDEAD_BEEF, 1'b1);

        // Reset at E2 of a 10-step SLL discards the operation.
        op_i    = 2'b00;
        data_i  = 32'h0000_0001;
        shamt_i = 5'd10;
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        checkOutput("midop_reset_busy", {31'b0, busy_o}, 32'd0);
        checkOutput("midop_reset_done", {31'b0, done_o}, 32'd0);
        checkOutput("midop_reset_data", data_o, 32'h0);
        lastResult = 32'h0;
        begin
            int lateDone;
            lateDone = 0;
            for (int i = 0; i < 15; i++) begin
                @(posedge clk_i);
                #1;
                if (done_o) lateDone++;
            end
            checkOutput("no_done_after_reset", 32'(lateDone), 32'd0);
        end

        // A fresh start after the reset completes normally.
        applyStimulus(2'b00, 32'h0000_0001, 5'd10, 32'h0000_0400, 1'b0);

        checkOutput("queue_empty", 32'(expQ.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
